// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - load/store unit between execute stage and a valid/ready data bus
// One bus transaction per memory instruction; stalls the core until done, with misalignment and timeout flags.

module dmem_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        dmem_req_i,
  input  logic        dmem_wr_en_i,
  input  logic [1:0]  dmem_size_i,
  input  logic        dmem_zero_extend_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wdata_i,
  output logic        lsu_stall_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_misaligned_o,
  output logic        lsu_bus_err_o,
  output logic        bus_req_valid_o,
  input  logic        bus_req_ready_i,
  output logic [31:0] bus_req_addr_o,
  output logic        bus_req_we_o,
  output logic [3:0]  bus_req_be_o,
  output logic [31:0] bus_req_wdata_o,
  input  logic        bus_rsp_valid_i,
  input  logic [31:0] bus_rsp_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [31:0]       addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              zext_q, zext_d;
  logic [1:0]        off_q, off_d;

  logic              misaligned_c;
  logic [3:0]        be_c;
  logic [31:0]       wdata_c;
  logic [31:0]       shifted_c;
  logic [31:0]       load_c;
  logic              stall_c;
  logic              mis_c;
  logic              valid_c;
  logic              timeout_c;

  // Size code 3 falls through to the word cases everywhere below.
  always_comb begin
    misaligned_c = 1'b0;
    be_c         = 4'hF;
    wdata_c      = dmem_wdata_i;
    case (dmem_size_i)
      SZ_BYTE: begin
        be_c    = 4'b0001 << dmem_addr_i[1:0];
        wdata_c = {4{dmem_wdata_i[7:0]}};
      end
      SZ_HALF: begin
        misaligned_c = dmem_addr_i[0];
        be_c         = 4'b0011 << dmem_addr_i[1:0];
        wdata_c      = {2{dmem_wdata_i[15:0]}};
      end
      default: begin
        misaligned_c = (dmem_addr_i[1:0] != 2'b00);
      end
    endcase
  end

  always_comb begin
    shifted_c = bus_rsp_rdata_i >> {off_q, 3'b000};
    case (size_q)
      SZ_BYTE: load_c = zext_q ? {24'h0, shifted_c[7:0]}
                               : {{24{shifted_c[7]}}, shifted_c[7:0]};
      SZ_HALF: load_c = zext_q ? {16'h0, shifted_c[15:0]}
                               : {{16{shifted_c[15]}}, shifted_c[15:0]};
      default: load_c = shifted_c;
    endcase
  end

  assign timeout_c = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    zext_d  = zext_q;
    off_d   = off_q;
    stall_c = 1'b0;
    mis_c   = 1'b0;
    valid_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dmem_req_i) begin
          if (misaligned_c) begin
            mis_c = 1'b1;
          end else begin
            stall_c = 1'b1;
            addr_d  = {dmem_addr_i[31:2], 2'b00};
            we_d    = dmem_wr_en_i;
            be_d    = be_c;
            wdata_d = wdata_c;
            size_d  = dmem_size_i;
            zext_d  = dmem_zero_extend_i;
            off_d   = dmem_addr_i[1:0];
            cnt_d   = '0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        valid_c = 1'b1;
        stall_c = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        // Acceptance on the final counted cycle still wins over the timeout.
        if (bus_req_ready_i) begin
          state_d = we_q ? S_DONE : S_WAIT;
        end else if (timeout_c) begin
          state_d = S_DONE;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      S_WAIT: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (bus_rsp_valid_i) begin
          state_d = S_DONE;
          rdata_d = load_c;
        end else if (timeout_c) begin
          state_d = S_DONE;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      zext_q  <= 1'b0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      zext_q  <= zext_d;
      off_q   <= off_d;
    end
  end

  // Combinational IDLE outputs are masked so nothing is requested while reset is held.
  assign lsu_stall_o      = stall_c & rst_ni;
  assign lsu_misaligned_o = mis_c & rst_ni;
  assign lsu_rdata_o      = rdata_q;
  assign lsu_bus_err_o    = err_q;
  assign bus_req_valid_o  = valid_c;
  assign bus_req_addr_o   = addr_q;
  assign bus_req_we_o     = we_q;
  assign bus_req_be_o     = be_q;
  assign bus_req_wdata_o  = wdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - directed self-checking bench for dmem_lsu
// Inputs change on the falling edge; outputs are sampled 1ns later.

module tb_dmem_lsu;

  localparam int unsigned TO = 8;

  logic        clk;
  logic        rst_n;
  logic        dmem_req;
  logic        dmem_wr_en;
  logic [1:0]  dmem_size;
  logic        dmem_zero_extend;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        lsu_stall;
  logic [31:0] lsu_rdata;
  logic        lsu_misaligned;
  logic        lsu_bus_err;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_req_addr;
  logic        bus_req_we;
  logic [3:0]  bus_req_be;
  logic [31:0] bus_req_wdata;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_rdata;

  int n_total = 0;
  int n_pass  = 0;

  int          r_stall;
  logic        r_saw_valid;
  logic        r_err;
  logic        r_mis;
  logic [31:0] r_rdata;
  logic [31:0] cap_addr;
  logic [3:0]  cap_be;
  logic        cap_we;
  logic [31:0] cap_wdata;

  dmem_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .dmem_req_i         (dmem_req),
    .dmem_wr_en_i       (dmem_wr_en),
    .dmem_size_i        (dmem_size),
    .dmem_zero_extend_i (dmem_zero_extend),
    .dmem_addr_i        (dmem_addr),
    .dmem_wdata_i       (dmem_wdata),
    .lsu_stall_o        (lsu_stall),
    .lsu_rdata_o        (lsu_rdata),
    .lsu_misaligned_o   (lsu_misaligned),
    .lsu_bus_err_o      (lsu_bus_err),
    .bus_req_valid_o    (bus_req_valid),
    .bus_req_ready_i    (bus_req_ready),
    .bus_req_addr_o     (bus_req_addr),
    .bus_req_we_o       (bus_req_we),
    .bus_req_be_o       (bus_req_be),
    .bus_req_wdata_o    (bus_req_wdata),
    .bus_rsp_valid_i    (bus_rsp_valid),
    .bus_rsp_rdata_i    (bus_rsp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Runs one memory instruction; the response arrives rsp_dly cycles after acceptance.
  task automatic do_txn(input logic we, input logic [1:0] sz, input logic zx,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic rdy, input int rsp_dly, input logic [31:0] rsp_data);
    bit pend;
    bit acc;
    int since;
    pend = 0;
    acc = 0;
    since = 0;
    r_stall = 0;
    r_saw_valid = 1'b0;
    @(negedge clk);
    dmem_req = 1'b1;
    dmem_wr_en = we;
    dmem_size = sz;
    dmem_zero_extend = zx;
    dmem_addr = addr;
    dmem_wdata = wd;
    bus_req_ready = rdy;
    bus_rsp_valid = 1'b0;
    bus_rsp_rdata = rsp_data;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (!lsu_stall) break;
      r_stall++;
      if (bus_req_valid) begin
        r_saw_valid = 1'b1;
        cap_addr = bus_req_addr;
        cap_be = bus_req_be;
        cap_we = bus_req_we;
        cap_wdata = bus_req_wdata;
        if (bus_req_ready) pend = 1;
      end
      @(negedge clk);
      if (acc) since++;
      if (pend && !acc) begin
        acc = 1;
        since = 1;
      end
      bus_rsp_valid = acc && (since == rsp_dly);
    end
    r_err = lsu_bus_err;
    r_mis = lsu_misaligned;
    r_rdata = lsu_rdata;
    dmem_req = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_req_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    dmem_req = 1'b1;
    dmem_wr_en = 1'b0;
    dmem_size = 2'd2;
    dmem_zero_extend = 1'b0;
    dmem_addr = 32'h0000_0100;
    dmem_wdata = 32'h0;
    bus_req_ready = 1'b1;
    bus_rsp_valid = 1'b0;
    bus_rsp_rdata = 32'h0;

    #2;
    chk("rst_stall", 32'(lsu_stall), 32'd0);
    chk("rst_valid", 32'(bus_req_valid), 32'd0);
    chk("rst_rdata", lsu_rdata, 32'h0);
    chk("rst_err", 32'(lsu_bus_err), 32'd0);
    chk("rst_mis", 32'(lsu_misaligned), 32'd0);
    chk("rst_addr", bus_req_addr, 32'h0);
    chk("rst_be", 32'(bus_req_be), 32'h0);
    dmem_req = 1'b0;
    bus_req_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    do_txn(1'b1, 2'd2, 1'b0, 32'h1000_0004, 32'hDEAD_BEEF, 1'b1, 0, 32'h0);
    chk("sw_stall", 32'(r_stall), 32'd2);
    chk("sw_addr", cap_addr, 32'h1000_0004);
    chk("sw_be", 32'(cap_be), 32'h0000_000F);
    chk("sw_we", 32'(cap_we), 32'd1);
    chk("sw_wdata", cap_wdata, 32'hDEAD_BEEF);
    chk("sw_err", 32'(r_err), 32'd0);

    do_txn(1'b1, 2'd0, 1'b0, 32'h0000_0013, 32'h0000_00A5, 1'b1, 0, 32'h0);
    chk("sb_addr", cap_addr, 32'h0000_0010);
    chk("sb_be", 32'(cap_be), 32'h0000_0008);
    chk("sb_wdata", cap_wdata, 32'hA5A5_A5A5);

    do_txn(1'b1, 2'd1, 1'b0, 32'h0000_0006, 32'h1234_ABCD, 1'b1, 0, 32'h0);
    chk("sh_addr", cap_addr, 32'h0000_0004);
    chk("sh_be", 32'(cap_be), 32'h0000_000C);
    chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);

    do_txn(1'b0, 2'd0, 1'b0, 32'h0000_0022, 32'h0, 1'b1, 3, 32'h1280_3456);
    chk("lb_stall", 32'(r_stall), 32'd5);
    chk("lb_rdata", r_rdata, 32'hFFFF_FF80);
    chk("lb_we", 32'(cap_we), 32'd0);
    chk("lb_addr", cap_addr, 32'h0000_0020);

    do_txn(1'b0, 2'd0, 1'b1, 32'h0000_0022, 32'h0, 1'b1, 3, 32'h1280_3456);
    chk("lbu_stall", 32'(r_stall), 32'd5);
    chk("lbu_rdata", r_rdata, 32'h0000_0080);

    do_txn(1'b0, 2'd1, 1'b0, 32'h0000_0002, 32'h0, 1'b1, 1, 32'h8001_0000);
    chk("lh_stall", 32'(r_stall), 32'd3);
    chk("lh_rdata", r_rdata, 32'hFFFF_8001);

    do_txn(1'b0, 2'd1, 1'b0, 32'h0000_0003, 32'h0, 1'b1, 1, 32'h0);
    chk("lh_mis_flag", 32'(r_mis), 32'd1);
    chk("lh_mis_stall", 32'(r_stall), 32'd0);
    chk("lh_mis_valid", 32'(r_saw_valid), 32'd0);
    chk("lh_mis_rdata", r_rdata, 32'hFFFF_8001);
    @(negedge clk);
    #1;
    chk("lh_mis_after_valid", 32'(bus_req_valid), 32'd0);

    do_txn(1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'h0, 1'b1, 1, 32'h0);
    chk("lw_mis_flag", 32'(r_mis), 32'd1);
    chk("lw_mis_stall", 32'(r_stall), 32'd0);
    @(negedge clk);
    #1;
    chk("lw_mis_after_valid", 32'(bus_req_valid), 32'd0);
    chk("lw_mis_after_mis", 32'(lsu_misaligned), 32'd0);

    do_txn(1'b1, 2'd2, 1'b0, 32'h0000_0008, 32'h5555_5555, 1'b1, 0, 32'h0);
    chk("sw_keeps_rdata", r_rdata, 32'hFFFF_8001);

    do_txn(1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 1'b1, 7, 32'h1234_5678);
    chk("lw_late_stall", 32'(r_stall), 32'd9);
    chk("lw_late_rdata", r_rdata, 32'h1234_5678);
    chk("lw_late_err", 32'(r_err), 32'd0);

    do_txn(1'b0, 2'd2, 1'b0, 32'h0000_0080, 32'h0, 1'b0, 99, 32'h0);
    chk("to_req_stall", 32'(r_stall), 32'd9);
    chk("to_req_err", 32'(r_err), 32'd1);
    chk("to_req_rdata", r_rdata, 32'h0);
    chk("to_req_addr", cap_addr, 32'h0000_0080);
    @(negedge clk);
    #1;
    chk("to_req_err_pulse", 32'(lsu_bus_err), 32'd0);
    chk("to_req_idle_stall", 32'(lsu_stall), 32'd0);

    do_txn(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 1'b1, 1, 32'hCAFE_F00D);
    chk("lw_stall", 32'(r_stall), 32'd3);
    chk("lw_rdata", r_rdata, 32'hCAFE_F00D);

    do_txn(1'b0, 2'd2, 1'b0, 32'h0000_0104, 32'h0, 1'b1, 99, 32'h0);
    chk("to_wait_stall", 32'(r_stall), 32'd9);
    chk("to_wait_err", 32'(r_err), 32'd1);
    chk("to_wait_rdata", r_rdata, 32'h0);

    do_txn(1'b0, 2'd2, 1'b0, 32'h0000_0108, 32'h0, 1'b1, 2, 32'h0BAD_F00D);
    chk("lw2_rdata", r_rdata, 32'h0BAD_F00D);

    @(negedge clk);
    dmem_req = 1'b1;
    dmem_wr_en = 1'b0;
    dmem_size = 2'd2;
    dmem_zero_extend = 1'b0;
    dmem_addr = 32'h0000_0200;
    bus_req_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("wr_req_valid", 32'(bus_req_valid), 32'd1);
    @(negedge clk);
    bus_req_ready = 1'b0;
    #1;
    chk("wr_wait_stall", 32'(lsu_stall), 32'd1);
    chk("wr_wait_valid", 32'(bus_req_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("wr_rst_stall", 32'(lsu_stall), 32'd0);
    chk("wr_rst_valid", 32'(bus_req_valid), 32'd0);
    chk("wr_rst_rdata", lsu_rdata, 32'h0);
    chk("wr_rst_addr", bus_req_addr, 32'h0);
    chk("wr_rst_err", 32'(lsu_bus_err), 32'd0);
    dmem_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    #1;
    chk("late_rsp_rdata", lsu_rdata, 32'h0);
    chk("late_rsp_stall", 32'(lsu_stall), 32'd0);
    chk("late_rsp_valid", 32'(bus_req_valid), 32'd0);
    bus_rsp_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("late_rsp_rdata2", lsu_rdata, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit between the execute stage and the data-memory bus. It consumes the memory-control outputs of the decoder (`dmem_req`, `dmem_wr_en`, `dmem_size`, `dmem_zero_extend`), the ALU-computed address and the rs2 store data. It runs one valid/ready bus transaction per memory instruction, stalls the core until the transaction completes, and returns a sign- or zero-extended load value for register write-back. Misaligned accesses are flagged without touching the bus, and a bus that never answers is bounded by a timeout.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 255. Maximum cycles spent in REQ+WAIT before a bus error is forced. Minimum value 2.

Ports (name, direction, width, meaning):
- `clk`  in  1  Single clock; everything is rising-edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `dmem_req`  in  1  Memory instruction present; held stable by the core while `lsu_stall`=1.
- `dmem_wr_en`  in  1  1 = store, 0 = load.
- `dmem_size`  in  2  `mem_size_t`: BYTE=0, HALF_WORD=1, WORD=2. Value 3 is treated as WORD.
- `dmem_zero_extend`  in  1  1 = LBU/LHU, 0 = sign-extend.
- `dmem_addr`  in  32  Byte address (ALU result).
- `dmem_wdata`  in  32  Store data (rs2).
- `lsu_stall`  out  1  Freezes the core pipeline.
- `lsu_rdata`  out  32  Extended load result.
- `lsu_misaligned`  out  1  Misaligned-access pulse.
- `lsu_bus_err`  out  1  Timeout pulse.
- `bus_req_valid`  out  1  Bus request valid.
- `bus_req_ready`  in  1  Bus request accepted.
- `bus_req_addr`  out  32  Word-aligned address, `{addr[31:2],2'b00}`.
- `bus_req_we`  out  1  Write enable.
- `bus_req_be`  out  4  Byte enables.
- `bus_req_wdata`  out  32  Lane-replicated write data.
- `bus_rsp_valid`  in  1  Read response valid (loads only).
- `bus_rsp_rdata`  in  32  Read response word.

## Operation

- The state machine has four states: IDLE, REQ, WAIT, DONE.
- Misaligned access:
  - HALF_WORD with `addr[0]`=1 is misaligned.
  - WORD with `addr[1:0]`≠0 is misaligned.
- IDLE behaviour:
  - If `dmem_req` and misaligned: `lsu_misaligned`=1 combinationally, `lsu_stall`=0, no bus activity, stay in IDLE.
  - If `dmem_req` and aligned: `lsu_stall`=1 combinationally. Register addr, we, be, wdata, size, zero_extend and `addr[1:0]`. Clear the timeout counter. Go to REQ.
- REQ:
  - `bus_req_valid`=1, driven only from registered fields.
  - On `bus_req_ready`: a store goes to DONE; a load goes to WAIT.
- WAIT:
  - On `bus_rsp_valid`: register the extended data into `lsu_rdata` and go to DONE.
  - `bus_rsp_valid` outside WAIT is ignored.
- DONE:
  - `lsu_stall`=0 and inputs are ignored. The core advances at the end of this cycle.
  - Next state is IDLE.
- Timeout:
  - The counter increments every cycle in REQ or WAIT.
  - When the count reaches `TIMEOUT_CYCLES`-1 without progress: go to DONE, set `lsu_rdata`=0, and pulse `lsu_bus_err` for the DONE cycle.
  - Progress (ready in REQ, rsp in WAIT) on that same cycle wins over the timeout.
- Byte lanes, with `o`=`addr[1:0]`:
  - BYTE: `be`=`4'b0001<<o`, `wdata`=`{4{wdata[7:0]}}`.
  - HALF_WORD: `be`=`4'b0011<<o`, `wdata`=`{2{wdata[15:0]}}`.
  - WORD: `be`=`4'hF`, `wdata` unchanged.
- Load extraction:
  - `s = rsp_rdata >> (8*o)`.
  - BYTE gives `s[7:0]`; HALF_WORD gives `s[15:0]`; WORD gives `s`.
  - The result is sign- or zero-extended to 32 bits per `dmem_zero_extend`.
- `lsu_rdata` holds its value until the next load completes or a timeout occurs. Stores do not modify it.

## Timing

- Reset values: state=IDLE; `lsu_rdata`, counter and all registered bus fields are 0; `bus_req_valid`, `lsu_bus_err` and `lsu_misaligned` are 0. `lsu_stall` is 0 while reset is asserted.
- Reset mid-transaction: the block returns to IDLE immediately and `bus_req_valid` drops asynchronously. Any later `bus_rsp_valid` is ignored.
- Store with zero-wait ready: IDLE, REQ, DONE. The stall lasts 2 cycles.
- Load with ready in REQ and response N cycles later (N≥1): the stall lasts 2+N cycles, and `lsu_rdata` is valid in DONE.
- Bus rules:
  - REQ fields stay stable while `bus_req_valid`=1 and `bus_req_ready`=0.
  - At most one outstanding transaction.
  - The response is never expected in the same cycle as acceptance.
- Misaligned accesses complete in 0 extra cycles.
- Back-to-back memory instructions: the second is sampled in the IDLE cycle after DONE.

## Test plan

- SW, addr 0x1000_0004, wdata 0xDEAD_BEEF, ready immediate -> `be`=4'hF, `bus_req_addr`=0x1000_0004, `we`=1; stall exactly 2 cycles.
- SB, addr 0x13, wdata 0x0000_00A5 -> `bus_req_addr`=0x10, `be`=4'b1000, `bus_req_wdata`=0xA5A5_A5A5.
- LB vs LBU, addr 0x22, `bus_rsp_rdata`=0x1280_3456 (response 3 cycles after accept) -> LB `lsu_rdata`=0xFFFF_FF80; LBU `lsu_rdata`=0x0000_0080; stall 5 cycles.
- LH, addr 0x3 -> `lsu_misaligned`=1 in the same cycle, `lsu_stall`=0, `bus_req_valid` never asserted; LW at 0x2 behaves the same.
- Load with `bus_req_ready` held at 0 and `TIMEOUT_CYCLES`=8 -> DONE after 8 REQ cycles, `lsu_bus_err` pulses 1 cycle, `lsu_rdata`=0.
- Assert `rst_n` low while in WAIT, then deassert and return a late `bus_rsp_valid` -> all outputs are 0 and the state is IDLE; the late response is ignored and `lsu_rdata` stays 0.
